// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router sizing constants for fifo, reg and fsm blocks
package router_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int DATA_W     = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W      = 7;

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination packet fifo with header-tagged entries and pkt_end flag
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_end
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH:0]     mem [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pkt_end_q, pkt_end_d;
    logic               wr_acc, rd_acc;
    logic [WIDTH:0]     rd_entry;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem[rd_ptr_q[AW-1:0]];

    assign data_out = dout_q;
    assign pkt_end  = pkt_end_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        pkt_end_d = 1'b0;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            dout_d   = '0;
            cnt_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = rd_entry[WIDTH-1:0];
                // Header entries reload the count with payload length plus the parity byte.
                if (rd_entry[WIDTH]) begin
                    cnt_d = {1'b0, rd_entry[7:2]} + CNT_ONE;
                end else if (cnt_q != '0) begin
                    cnt_d     = cnt_q - CNT_ONE;
                    pkt_end_d = (cnt_q == CNT_ONE);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dout_q    <= '0;
            cnt_q     <= '0;
            pkt_end_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
            pkt_end_q <= pkt_end_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc && !soft_reset) begin
            mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule
